nibble_bus_sram: RTL and testbench

Synthesizable, parametrised memory target for the CPU's nibble-multiplexed external bus. It replaces the behavioural SRAM model with a real block. It decodes address strobes and nibble data beats from the CPU output byte and serves read nibbles back. New over the previous model: configurable word width (nibbles per word), optional address auto-increment for burst access, and a host preload/debug port arbitrated against CPU writes.

---
 rtl/nibble_bus_sram_pkg.sv | 32 +++
 rtl/nibble_bus_sram_word_asm.sv | 78 +++++++
 rtl/nibble_bus_sram.sv | 155 +++++++++++++++
 tb/tb_nibble_bus_sram.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_bus_sram_pkg.sv
// Shared definitions for the nibble-multiplexed bus SRAM target.
//   - Field positions inside the CPU output byte (strobe, write_n, nibble).
//   - Nibble width.
//   - Host port FSM state encoding.
//   - Small decode helpers for the bus byte.
package nibble_bus_pkg;

  localparam int BUS_W   = 8;
  localparam int STB_BIT = 7;
  localparam int WRN_BIT = 5;
  localparam int NIB_LSB = 0;
  localparam int NIB_W   = 4;

  typedef enum logic [0:0] {
    HS_IDLE = 1'b0,
    HS_ACK  = 1'b1
  } host_state_e;

  // A byte with the strobe bit set carries an address, otherwise a data beat.
  function automatic logic bus_is_strobe(input logic [BUS_W-1:0] b);
    return b[STB_BIT];
  endfunction

  function automatic logic bus_write_n(input logic [BUS_W-1:0] b);
    return b[WRN_BIT];
  endfunction

  function automatic logic [NIB_W-1:0] bus_nibble(input logic [BUS_W-1:0] b);
    return b[NIB_LSB +: NIB_W];
  endfunction

endpackage

// File: rtl/nibble_bus_sram_word_asm.sv
// nibble_word_asm: tracks the nibble position inside the current bus word,
// collects write nibbles and flags the edge at which a full write word is
// committed.
//   clk, rst   : clock, asynchronous active-high reset
//   bus_out    : CPU output byte (strobe / data beat)
//   nib_sel    : current nibble index (0 = most significant nibble)
//   word_end   : data beat on the last nibble of a word
//   commit     : word_end with an all-write word; write word_data this edge
//   word_data  : collected nibbles plus the nibble on the bus right now
module nibble_word_asm
  import nibble_bus_pkg::*;
#(
  parameter  int NIBBLES = 2,
  localparam int DATA_W  = NIB_W * NIBBLES,
  localparam int WBUF_W  = DATA_W - NIB_W,
  localparam int NSEL_W  = (NIBBLES > 1) ? $clog2(NIBBLES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BUS_W-1:0]  bus_out,
  output logic [NSEL_W-1:0] nib_sel,
  output logic              word_end,
  output logic              commit,
  output logic [DATA_W-1:0] word_data
);

  localparam logic [NSEL_W-1:0] NIB_LAST = NSEL_W'(NIBBLES - 1);

  logic [NSEL_W-1:0] nib_r;
  logic [WBUF_W-1:0] wbuf_r;
  logic              wr_ok_r;

  logic              strobe_s;
  logic              write_n_s;
  logic [NIB_W-1:0]  wnib_s;
  logic              last_s;
  logic              bus_unused_s;

  assign strobe_s     = bus_is_strobe(bus_out);
  assign write_n_s    = bus_write_n(bus_out);
  assign wnib_s       = bus_nibble(bus_out);
  assign last_s       = (nib_r == NIB_LAST);
  assign bus_unused_s = ^bus_out;

  assign word_end  = ~strobe_s & last_s;
  // No commit while reset is held so a reset never lands a partial word.
  assign commit    = word_end & ~write_n_s & wr_ok_r & ~rst;
  assign word_data = {wbuf_r, wnib_s};
  assign nib_sel   = nib_r;

  // Nibble position, write buffer and "all beats were writes" flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nib_r   <= '0;
      wbuf_r  <= '0;
      wr_ok_r <= 1'b1;
    end else if (strobe_s) begin
      nib_r   <= '0;
      wr_ok_r <= 1'b1;
    end else if (last_s) begin
      // Word boundary: the last nibble goes straight to memory via word_data.
      nib_r   <= '0;
      wr_ok_r <= 1'b1;
    end else begin
      nib_r <= nib_r + NSEL_W'(1);
      if (write_n_s) begin
        wr_ok_r <= 1'b0;
      end else begin
        for (int i = 0; i < NIBBLES - 1; i++) begin
          if (nib_r == NSEL_W'(i)) begin
            wbuf_r[WBUF_W-1-NIB_W*i -: NIB_W] <= wnib_s;
          end
        end
      end
    end
  end

endmodule

// File: rtl/nibble_bus_sram.sv
// nibble_bus_sram: memory target for the CPU nibble-multiplexed bus with a
// host preload/debug port.
//   clk, rst    : clock, asynchronous active-high reset
//   bus_out     : CPU output byte ([7]=strobe, else [5]=write_n, [3:0]=nibble)
//   bus_nib     : read nibble at (addr, nib_sel), combinational
//   nib_sel     : current nibble index within the word
//   host_req    : host access request (level)
//   host_we     : 1 = host write, 0 = host read
//   host_addr   : host word address
//   host_wdata  : host write data
//   host_ack    : one-cycle completion pulse
//   host_rdata  : host read data, held until the next ack
// The memory array is not reset. CPU commits win over host accesses; a host
// request that collides with a commit is retried on the following cycle.
module nibble_bus_sram
  import nibble_bus_pkg::*;
#(
  parameter  int ADDR_W   = 7,
  parameter  int NIBBLES  = 2,
  parameter  int AUTO_INC = 1,
  localparam int DATA_W   = NIB_W * NIBBLES,
  localparam int DEPTH    = 2 ** ADDR_W,
  localparam int NSEL_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BUS_W-1:0]  bus_out,
  output logic [NIB_W-1:0]  bus_nib,
  output logic [NSEL_W-1:0] nib_sel,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata
);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [ADDR_W-1:0] addr_r;
  host_state_e       hstate_r;
  host_state_e       hstate_nxt_s;
  logic              host_ack_r;
  logic [DATA_W-1:0] host_rdata_r;

  logic [NSEL_W-1:0] nib_sel_s;
  logic              word_end_s;
  logic              cpu_commit_s;
  logic [DATA_W-1:0] word_data_s;
  logic              host_fire_s;
  logic [DATA_W-1:0] rd_word_s;
  logic [DATA_W-1:0] rd_shift_s;
  logic [7:0]        nib_ofs_s;
  logic              bus_unused_s;

  assign bus_unused_s = ^bus_out;

  nibble_word_asm #(
    .NIBBLES (NIBBLES)
  ) u_word_asm (
    .clk       (clk),
    .rst       (rst),
    .bus_out   (bus_out),
    .nib_sel   (nib_sel_s),
    .word_end  (word_end_s),
    .commit    (cpu_commit_s),
    .word_data (word_data_s)
  );

  // Word address: loaded by a strobe, optionally stepped at each word end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_r <= '0;
    end else if (bus_is_strobe(bus_out)) begin
      addr_r <= bus_out[ADDR_W-1:0];
    end else if (word_end_s && (AUTO_INC != 0)) begin
      addr_r <= addr_r + ADDR_W'(1);
    end
  end

  // Memory array write port; CPU commit has priority over the host.
  always_ff @(posedge clk) begin
    if (cpu_commit_s) begin
      mem_r[addr_r] <= word_data_s;
    end else if (host_fire_s && host_we) begin
      mem_r[host_addr] <= host_wdata;
    end
  end

  // Host FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hstate_r <= HS_IDLE;
    end else begin
      hstate_r <= hstate_nxt_s;
    end
  end

  // Host FSM next state: ACK always lasts one cycle and ignores host_req.
  always_comb begin
    hstate_nxt_s = hstate_r;
    case (hstate_r)
      HS_IDLE: begin
        if (host_req && !cpu_commit_s) begin
          hstate_nxt_s = HS_ACK;
        end else begin
          hstate_nxt_s = HS_IDLE;
        end
      end
      HS_ACK:  hstate_nxt_s = HS_IDLE;
      default: hstate_nxt_s = HS_IDLE;
    endcase
  end

  // Host FSM outputs: the access is performed on the IDLE -> ACK edge.
  always_comb begin
    host_fire_s = 1'b0;
    case (hstate_r)
      HS_IDLE: begin
        if (host_req && !cpu_commit_s && !rst) begin
          host_fire_s = 1'b1;
        end else begin
          host_fire_s = 1'b0;
        end
      end
      HS_ACK:  host_fire_s = 1'b0;
      default: host_fire_s = 1'b0;
    endcase
  end

  // Registered host ack pulse and read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      host_ack_r   <= 1'b0;
      host_rdata_r <= '0;
    end else begin
      host_ack_r <= host_fire_s;
      if (host_fire_s && !host_we) begin
        host_rdata_r <= mem_r[host_addr];
      end
    end
  end

  // CPU read path: shift the selected nibble to the top of the word.
  always_comb begin
    rd_word_s  = mem_r[addr_r];
    nib_ofs_s  = 8'({nib_sel_s, 2'b00});
    rd_shift_s = rd_word_s << nib_ofs_s;
  end

  assign bus_nib    = rd_shift_s[DATA_W-1 -: NIB_W];
  assign nib_sel    = nib_sel_s;
  assign host_ack   = host_ack_r;
  assign host_rdata = host_rdata_r;

endmodule

// File: tb/tb_nibble_bus_sram.sv
// Directed bench for nibble_bus_sram: a per-cycle vector table on the default
// configuration (with an AUTO_INC=0 twin fed the same inputs), followed by
// hand-written collision and NIBBLES=4 / reset-mid-word sequences.
module tb_nibble_bus_sram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance and AUTO_INC=0 twin share all inputs.
  logic       rst;
  logic [7:0] bus;
  logic       hreq, hwe;
  logic [6:0] haddr;
  logic [7:0] hwd;
  logic [3:0] nib_a, nib_b;
  logic [0:0] sel_a, sel_b;
  logic       ack_a, ack_b;
  logic [7:0] rd_a, rd_b;

  // NIBBLES=4 instance.
  logic        rst4;
  logic [7:0]  bus4;
  logic        hreq4, hwe4;
  logic [6:0]  haddr4;
  logic [15:0] hwd4;
  logic [3:0]  nib4;
  logic [1:0]  sel4;
  logic        ack4;
  logic [15:0] rd4;

  int checks   = 0;
  int failures = 0;

  nibble_bus_sram #(.ADDR_W(7), .NIBBLES(2), .AUTO_INC(1)) dut (
    .clk(clk), .rst(rst), .bus_out(bus), .bus_nib(nib_a), .nib_sel(sel_a),
    .host_req(hreq), .host_we(hwe), .host_addr(haddr), .host_wdata(hwd),
    .host_ack(ack_a), .host_rdata(rd_a));

  nibble_bus_sram #(.ADDR_W(7), .NIBBLES(2), .AUTO_INC(0)) dut_ni (
    .clk(clk), .rst(rst), .bus_out(bus), .bus_nib(nib_b), .nib_sel(sel_b),
    .host_req(hreq), .host_we(hwe), .host_addr(haddr), .host_wdata(hwd),
    .host_ack(ack_b), .host_rdata(rd_b));

  nibble_bus_sram #(.ADDR_W(7), .NIBBLES(4), .AUTO_INC(1)) dut4 (
    .clk(clk), .rst(rst4), .bus_out(bus4), .bus_nib(nib4), .nib_sel(sel4),
    .host_req(hreq4), .host_we(hwe4), .host_addr(haddr4), .host_wdata(hwd4),
    .host_ack(ack4), .host_rdata(rd4));

  typedef struct {
    logic [7:0] bus;
    logic       hreq;
    logic       hwe;
    logic [6:0] haddr;
    logic [7:0] hwd;
    logic [0:0] sel;
    logic       ack;
    logic       cn;
    logic [3:0] nib;
    logic       cr;
    logic [7:0] rd;
    logic       cb;
    logic [3:0] nib_b;
  } vec_t;

  localparam int NV = 30;
  vec_t vt [NV];

  function automatic vec_t mk(input logic [7:0] b, input logic rq, input logic we,
                              input logic [6:0] ad, input logic [7:0] wd,
                              input logic [0:0] sl, input logic ak,
                              input logic cn, input logic [3:0] nb,
                              input logic cr, input logic [7:0] rd,
                              input logic cb, input logic [3:0] nbb);
    vec_t v;
    v.bus = b; v.hreq = rq; v.hwe = we; v.haddr = ad; v.hwd = wd;
    v.sel = sl; v.ack = ak; v.cn = cn; v.nib = nb; v.cr = cr; v.rd = rd;
    v.cb = cb; v.nib_b = nbb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // bus, hreq, hwe, haddr, hwd | sel, ack, cn, nib, cr, rd, cb, nib_b
    // Host write 0xA5 to 0x10, CPU reads it back; preload 0x21 = 0x7E.
    vt[0]  = mk(8'h90, 1'b1, 1'b1, 7'h10, 8'hA5, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 8'h00, 1'b0, 4'h0);
    vt[1]  = mk(8'h90, 1'b0, 1'b0, 7'h00, 8'h00, 1'b0, 1'b1, 1'b1, 4'hA, 1'b1, 8'h00, 1'b1, 4'hA);
    vt[2]  = mk(8'h20, 1'b1, 1'b1, 7'h21, 8'h7E, 1'b0, 1'b0, 1'b1, 4'hA, 1'b0, 8'h00, 1'b0, 4'h0);
    vt[3]  = mk(8'h20, 1'b0, 1'b0, 7'h00, 8'h00, 1'b1, 1'b1, 1'b1, 4'h5, 1'b0, 8'h00, 1'b0, 4'h0);
    // CPU writes 0x3C to 0x20, host reads it, next beat reads mem[0x21].
    vt[4]  = mk(8'hA0, 1'b0, 1'b0, 7'h00, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 4'h0);
    vt[5]  = mk(8'h03, 1'b0, 1'b0, 7'h00, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 4'h0);
    vt[6]  = mk(8'h0C, 1'b0, 1'b0, 7'h00, 8'h00, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 4'h0);
    vt[7]  = mk(8'h20, 1'b1, 1'b0, 7'h20, 8'h00, 1'b0, 1'b0, 1'b1, 4'h7, 1'b0, 8'h00, 1'b0, 4'h0);
    vt[8]  = mk(8'h20, 1'b0, 1'b0, 7'h00, 8'h00, 1'b1, 1'b1, 1'b1, 4'hE, 1'b1, 8'h3C, 1'b0, 4'h0);
    // Preload 0x40 = 0x11, then write-then-read word (aborted).
    vt[9]  = mk(8'hC0, 1'b1, 1'b1, 7'h40, 8'h11, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 8'h3C, 1'b0, 4'h0);
    vt[10] = mk(8'h09, 1'b0, 1'b0, 7'h00, 8'h00, 1'b0, 1'b1, 1'b1, 4'h1, 1'b0, 8'h00, 1'b0, 4'h0);
    vt[11] = mk(8'h20, 1'b0, 1'b0, 7'h00, 8'h00, 1'b1, 1'b0, 1'b1, 4'h1, 1'b0, 8'h00, 1'b0, 4'h0);
    // Read-then-write word to 0x40 (aborted), then full write 0x28 to 0x41.
    vt[12] = mk(8'hC0, 1'b0, 1'b0, 7'h00, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 4'h0);
    vt[13] = mk(8'h20, 1'b0, 1'b0, 7'h00, 8'h00, 1'b0, 1'b0, 1'b1, 4'h1, 1'b0, 8'h00, 1'b0, 4'h0);
    vt[14] = mk(8'h07, 1'b0, 1'b0, 7'h00, 8'h00, 1'b1, 1'b0, 1'b1, 4'h1, 1'b0, 8'h00, 1'b0, 4'h0);
    vt[15] = mk(8'h02, 1'b0, 1'b0, 7'h00, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 4'h0);
    vt[16] = mk(8'h08, 1'b0, 1'b0, 7'h00, 8'h00, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 4'h0);
    vt[17] = mk(8'hC0, 1'b1, 1'b0, 7'h40, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 4'h0);
    vt[18] = mk(8'hC1, 1'b0, 1'b0, 7'h00, 8'h00, 1'b0, 1'b1, 1'b1, 4'h1, 1'b1, 8'h11, 1'b0, 4'h0);
    vt[19] = mk(8'hC1, 1'b1, 1'b0, 7'h41, 8'h00, 1'b0, 1'b0, 1'b1, 4'h2, 1'b0, 8'h00, 1'b0, 4'h0);
    vt[20] = mk(8'hC1, 1'b0, 1'b0, 7'h00, 8'h00, 1'b0, 1'b1, 1'b1, 4'h2, 1'b1, 8'h28, 1'b0, 4'h0);
    // Burst across the top of memory: 0x7F = 0x6B, 0x00 = 0xD2.
    vt[21] = mk(8'hFF, 1'b1, 1'b1, 7'h7F, 8'h6B, 1'b0, 1'b0, 1'b1, 4'h2, 1'b0, 8'h00, 1'b0, 4'h0);
    vt[22] = mk(8'hFF, 1'b0, 1'b0, 7'h00, 8'h00, 1'b0, 1'b1, 1'b1, 4'h6, 1'b0, 8'h00, 1'b1, 4'h6);
    vt[23] = mk(8'hFF, 1'b1, 1'b1, 7'h00, 8'hD2, 1'b0, 1'b0, 1'b1, 4'h6, 1'b0, 8'h00, 1'b1, 4'h6);
    vt[24] = mk(8'h20, 1'b0, 1'b0, 7'h00, 8'h00, 1'b0, 1'b1, 1'b1, 4'h6, 1'b0, 8'h00, 1'b1, 4'h6);
    vt[25] = mk(8'h20, 1'b0, 1'b0, 7'h00, 8'h00, 1'b1, 1'b0, 1'b1, 4'hB, 1'b0, 8'h00, 1'b1, 4'hB);
    vt[26] = mk(8'h20, 1'b0, 1'b0, 7'h00, 8'h00, 1'b0, 1'b0, 1'b1, 4'hD, 1'b0, 8'h00, 1'b1, 4'h6);
    vt[27] = mk(8'h20, 1'b0, 1'b0, 7'h00, 8'h00, 1'b1, 1'b0, 1'b1, 4'h2, 1'b0, 8'h00, 1'b1, 4'hB);
    vt[28] = mk(8'h80, 1'b0, 1'b0, 7'h00, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 8'h00, 1'b1, 4'h6);
    vt[29] = mk(8'h80, 1'b0, 1'b0, 7'h00, 8'h00, 1'b0, 1'b0, 1'b1, 4'hD, 1'b0, 8'h00, 1'b1, 4'hD);

    // Reset both configurations.
    rst = 1'b1; rst4 = 1'b1;
    bus = 8'h80; hreq = 1'b0; hwe = 1'b0; haddr = 7'h00; hwd = 8'h00;
    bus4 = 8'h80; hreq4 = 1'b0; hwe4 = 1'b0; haddr4 = 7'h00; hwd4 = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; rst4 = 1'b0;
    @(negedge clk);
    chk("rst_sel",   32'(sel_a), 32'h0);
    chk("rst_ack",   32'(ack_a), 32'h0);
    chk("rst_rdata", 32'(rd_a),  32'h0);
    chk("rst_sel4",  32'(sel4),  32'h0);
    chk("rst_ack4",  32'(ack4),  32'h0);
    chk("rst_rd4",   32'(rd4),   32'h0);
    tick();

    // Per-cycle vector table on the NIBBLES=2 pair.
    for (int k = 0; k < NV; k++) begin
      bus = vt[k].bus; hreq = vt[k].hreq; hwe = vt[k].hwe;
      haddr = vt[k].haddr; hwd = vt[k].hwd;
      @(negedge clk);
      chk($sformatf("v%0d_sel", k), 32'(sel_a), 32'(vt[k].sel));
      chk($sformatf("v%0d_ack", k), 32'(ack_a), 32'(vt[k].ack));
      if (vt[k].cn) chk($sformatf("v%0d_nib", k), 32'(nib_a), 32'(vt[k].nib));
      if (vt[k].cr) chk($sformatf("v%0d_rdata", k), 32'(rd_a), 32'(vt[k].rd));
      if (vt[k].cb) chk($sformatf("v%0d_nib_noinc", k), 32'(nib_b), 32'(vt[k].nib_b));
      tick();
    end

    // Collision: CPU commits 0x55 to 0x30 while the host writes 0xAA there.
    bus = 8'hB0; hreq = 1'b0; tick();
    bus = 8'h05; @(negedge clk); chk("col_sel0", 32'(sel_a), 32'h0); tick();
    bus = 8'h05; hreq = 1'b1; hwe = 1'b1; haddr = 7'h30; hwd = 8'hAA;
    @(negedge clk);
    chk("col_sel1", 32'(sel_a), 32'h1);
    chk("col_ack_n0", 32'(ack_a), 32'h0);
    tick();
    bus = 8'hB0;
    @(negedge clk);
    chk("col_ack_n1", 32'(ack_a), 32'h0);
    chk("col_cpu_first", 32'(nib_b), 32'h5);
    tick();
    hreq = 1'b0;
    @(negedge clk);
    chk("col_ack_n2", 32'(ack_a), 32'h1);
    chk("col_final_nib", 32'(nib_a), 32'hA);
    chk("col_final_nib_noinc", 32'(nib_b), 32'hA);
    tick();
    hreq = 1'b1; hwe = 1'b0; haddr = 7'h30;
    @(negedge clk); chk("col_ack_end", 32'(ack_a), 32'h0); tick();
    hreq = 1'b0;
    @(negedge clk);
    chk("col_rd_ack", 32'(ack_a), 32'h1);
    chk("col_rdata", 32'(rd_a), 32'hAA);
    tick();

    // NIBBLES=4: write 0x1234 to 0x05 and read it back over the host port.
    bus4 = 8'h85; tick();
    for (int i = 0; i < 4; i++) begin
      bus4 = 8'(i + 1);
      @(negedge clk);
      chk($sformatf("n4_sel%0d", i), 32'(sel4), 32'(i));
      tick();
    end
    bus4 = 8'h85; hreq4 = 1'b1; hwe4 = 1'b0; haddr4 = 7'h05;
    @(negedge clk); chk("n4_sel_wrap", 32'(sel4), 32'h0); tick();
    hreq4 = 1'b0;
    @(negedge clk);
    chk("n4_ack", 32'(ack4), 32'h1);
    chk("n4_rdata", 32'(rd4), 32'h1234);
    chk("n4_nib0", 32'(nib4), 32'h1);
    tick();

    // Repeat with new data, reset after the second beat with a request up.
    bus4 = 8'h0A; tick();
    bus4 = 8'h0B; @(negedge clk); chk("n4r_sel1", 32'(sel4), 32'h1); tick();
    bus4 = 8'h0C; hreq4 = 1'b1; hwe4 = 1'b0; haddr4 = 7'h05;
    rst4 = 1'b1;
    #1;
    chk("n4r_rst_sel", 32'(sel4), 32'h0);
    chk("n4r_rst_ack", 32'(ack4), 32'h0);
    chk("n4r_rst_rd",  32'(rd4),  32'h0);
    tick();
    bus4 = 8'h0D; tick();
    chk("n4r_hold_ack", 32'(ack4), 32'h0);
    rst4 = 1'b0; hreq4 = 1'b0; bus4 = 8'h85;
    @(negedge clk);
    chk("n4r_drop_ack", 32'(ack4), 32'h0);
    chk("n4r_sel_after", 32'(sel4), 32'h0);
    tick();
    hreq4 = 1'b1;
    @(negedge clk); chk("n4r_nib0", 32'(nib4), 32'h1); tick();
    hreq4 = 1'b0;
    @(negedge clk);
    chk("n4r_ack", 32'(ack4), 32'h1);
    chk("n4r_mem_kept", 32'(rd4), 32'h1234);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
